// File: rtl/piso_pkg.sv
// ---------------------------------------------------------------------------
// piso_pkg
//   Types and helpers shared by the parallel-in, serial-out buffer.
//   - piso_state_e : control state (IDLE = empty, BUSY = draining a vector)
//   - piso_ptr_w() : read-pointer width for a given element count
// ---------------------------------------------------------------------------
package piso_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } piso_state_e;

    // The pointer only has to reach depth-1, so clog2(depth) bits suffice.
    // The guard keeps a degenerate depth from producing a zero-width vector.
    function automatic int piso_ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/piso_if.sv
// ---------------------------------------------------------------------------
// piso_if
//   Handshake bundle around the parallel-in, serial-out buffer.
//   Parallel side : valid_i, ready_o, data_i (width_p*depth_p bits)
//   Serial side   : valid_o, ready_i, data_o (width_p bits), last_o
//   Modports:
//     slave  - the buffer itself (consumes the vector, produces elements)
//     master - the environment (producer upstream + consumer downstream)
// ---------------------------------------------------------------------------
interface piso_if #(
    parameter int width_p = 8,
    parameter int depth_p = 128
);
    logic                       valid_i;
    logic                       ready_o;
    logic [width_p*depth_p-1:0] data_i;
    logic                       valid_o;
    logic                       ready_i;
    logic [width_p-1:0]         data_o;
    logic                       last_o;

    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, last_o
    );

    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, last_o
    );
endinterface

// File: rtl/piso.sv
// ---------------------------------------------------------------------------
// piso
//   Parallel-in, serial-out buffer. Captures a whole vector of depth_p
//   elements in one handshake, then emits the elements one per handshake,
//   element 0 (data_i[width_p-1:0]) first.
//   Ports:
//     clk_i   - clock, rising edge
//     reset_i - asynchronous active-low reset
//     bus     - piso_if.slave: valid_i/ready_o/data_i (parallel in),
//               valid_o/ready_i/data_o/last_o (serial out)
//   ready_o depends combinationally on ready_i so a new vector can be
//   loaded on the same edge the final element leaves (zero bubble).
// ---------------------------------------------------------------------------
module piso
    import piso_pkg::*;
#(
    parameter int width_p = 8,
    parameter int depth_p = 128
) (
    input logic   clk_i,
    input logic   reset_i,
    piso_if.slave bus
);

    localparam int                   ptr_w_lp    = piso_ptr_w(depth_p);
    localparam logic [ptr_w_lp-1:0]  last_idx_lp = ptr_w_lp'(depth_p - 1);

    piso_state_e         state_r, state_n;
    logic [ptr_w_lp-1:0] rd_ptr_r, rd_ptr_n;
    logic [width_p-1:0]  mem [depth_p];

    logic busy;
    logic at_last;
    logic load;
    logic fire;

    assign busy    = (state_r == BUSY);
    assign at_last = busy && (rd_ptr_r == last_idx_lp);
    assign fire    = busy && bus.ready_i;
    assign load    = bus.valid_i && bus.ready_o;

    assign bus.valid_o = busy;
    assign bus.last_o  = at_last;
    assign bus.data_o  = mem[rd_ptr_r];
    assign bus.ready_o = !busy || (at_last && bus.ready_i);

    // Control state; asynchronous reset empties the buffer immediately.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r  <= IDLE;
            rd_ptr_r <= '0;
        end else begin
            state_r  <= state_n;
            rd_ptr_r <= rd_ptr_n;
        end
    end

    // Vector storage is data only and carries no reset.
    always_ff @(posedge clk_i) begin
        if (load) begin
            for (int i = 0; i < depth_p; i++) begin
                mem[i] <= bus.data_i[i*width_p +: width_p];
            end
        end
    end

    // Wrap is explicit at the last element so a non-power-of-two depth never
    // walks the pointer past depth_p-1. A load on the final fire overrides
    // the return to IDLE and restarts at element 0.
    always_comb begin
        state_n  = state_r;
        rd_ptr_n = rd_ptr_r;
        if (fire) begin
            if (at_last) begin
                rd_ptr_n = '0;
                state_n  = IDLE;
            end else begin
                rd_ptr_n = rd_ptr_r + 1'b1;
            end
        end
        if (load) begin
            rd_ptr_n = '0;
            state_n  = BUSY;
        end
    end

endmodule

// File: tb/tb_piso.sv
// ---------------------------------------------------------------------------
// tb_piso
//   Directed bench for piso: a 4x8 instance driven from a vector table plus
//   hand-written sequences, and a 3x4 instance for the non-power-of-two case.
// ---------------------------------------------------------------------------
module tb_piso;

    logic clk;
    logic reset_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    piso_if #(.width_p(8), .depth_p(4)) bus4 ();
    piso_if #(.width_p(4), .depth_p(3)) bus3 ();

    piso #(.width_p(8), .depth_p(4)) dut4 (
        .clk_i   (clk),
        .reset_i (reset_n),
        .bus     (bus4.slave)
    );

    piso #(.width_p(4), .depth_p(3)) dut3 (
        .clk_i   (clk),
        .reset_i (reset_n),
        .bus     (bus3.slave)
    );

    int total;
    int bad;
    int fires;

    typedef struct {
        logic        vi;
        logic [31:0] di;
        logic        ri;
        logic        ev;
        logic [7:0]  ed;
        logic        el;
        logic        er;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic vi, input logic [31:0] di, input logic ri,
                                input logic ev, input logic [7:0] ed, input logic el,
                                input logic er);
        vec_t v;
        v.vi = vi; v.di = di; v.ri = ri;
        v.ev = ev; v.ed = ed; v.el = el; v.er = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the 4x8 outputs at the current moment.
    task automatic chk4(input string nm, input logic ev, input logic [7:0] ed,
                        input logic el, input logic er);
        chk({nm, ".valid"}, 32'(bus4.valid_o), 32'(ev));
        chk({nm, ".last"},  32'(bus4.last_o),  32'(el));
        chk({nm, ".ready"}, 32'(bus4.ready_o), 32'(er));
        if (ev) chk({nm, ".data"}, 32'(bus4.data_o), 32'(ed));
    endtask

    task automatic chk3(input string nm, input logic ev, input logic [3:0] ed,
                        input logic el);
        chk({nm, ".valid"}, 32'(bus3.valid_o), 32'(ev));
        chk({nm, ".last"},  32'(bus3.last_o),  32'(el));
        if (ev) chk({nm, ".data"}, 32'(bus3.data_o), 32'(ed));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b2b_d [8];
        logic       b2b_l [8];
        logic       b2b_r [8];
        logic [3:0] d3    [6];
        logic       l3    [6];

        total = 0;
        bad   = 0;
        fires = 0;

        // Vector 1: plain drain with ready_i held high.
        tbl[0]  = mk(1, 32'h44332211, 1, 0, 8'h00, 0, 1);
        tbl[1]  = mk(0, 32'h00000000, 1, 1, 8'h11, 0, 0);
        tbl[2]  = mk(0, 32'h00000000, 1, 1, 8'h22, 0, 0);
        tbl[3]  = mk(0, 32'h00000000, 1, 1, 8'h33, 0, 0);
        tbl[4]  = mk(0, 32'h00000000, 1, 1, 8'h44, 1, 1);
        tbl[5]  = mk(0, 32'h00000000, 1, 0, 8'h00, 0, 1);
        // Vector 2: ready_i pattern 1,0,0,1,1,0,1; data_i scrambled after load.
        tbl[6]  = mk(1, 32'h44332211, 0, 0, 8'h00, 0, 1);
        tbl[7]  = mk(0, 32'hFFEEDDCC, 1, 1, 8'h11, 0, 0);
        tbl[8]  = mk(0, 32'hFFEEDDCC, 0, 1, 8'h22, 0, 0);
        tbl[9]  = mk(0, 32'hFFEEDDCC, 0, 1, 8'h22, 0, 0);
        tbl[10] = mk(0, 32'hFFEEDDCC, 1, 1, 8'h22, 0, 0);
        tbl[11] = mk(0, 32'hFFEEDDCC, 1, 1, 8'h33, 0, 0);
        tbl[12] = mk(0, 32'hFFEEDDCC, 0, 1, 8'h44, 1, 0);
        tbl[13] = mk(0, 32'hFFEEDDCC, 1, 1, 8'h44, 1, 1);
        tbl[14] = mk(0, 32'h00000000, 1, 0, 8'h00, 0, 1);

        reset_n      = 1'b0;
        bus4.valid_i = 1'b0;
        bus4.data_i  = '0;
        bus4.ready_i = 1'b0;
        bus3.valid_i = 1'b0;
        bus3.data_i  = '0;
        bus3.ready_i = 1'b0;

        // Reset state, before any clock edge.
        #1;
        chk4("reset", 0, 8'h00, 0, 1);
        chk3("reset3", 0, 4'h0, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            bus4.valid_i = tbl[i].vi;
            bus4.data_i  = tbl[i].di;
            bus4.ready_i = tbl[i].ri;
            #1;
            chk4($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].er);
            if (bus4.valid_o && bus4.ready_i) fires++;
            tick();
        end
        chk("fire_count", 32'(fires), 32'd8);

        // Back-to-back vectors, valid_i held high throughout.
        b2b_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        b2b_l = '{0, 0, 0, 1, 0, 0, 0, 1};
        b2b_r = '{0, 0, 0, 1, 0, 0, 0, 1};
        bus4.valid_i = 1'b1;
        bus4.data_i  = 32'h44332211;
        bus4.ready_i = 1'b1;
        #1;
        chk4("b2b_load", 0, 8'h00, 0, 1);
        tick();
        bus4.data_i = 32'hDDCCBBAA;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) bus4.valid_i = 1'b0;
            #1;
            chk4($sformatf("b2b%0d", i), 1, b2b_d[i], b2b_l[i], b2b_r[i]);
            tick();
        end
        #1;
        chk4("b2b_end", 0, 8'h00, 0, 1);

        // Reset mid-vector after 22 has been consumed.
        bus4.valid_i = 1'b1;
        bus4.data_i  = 32'h44332211;
        bus4.ready_i = 1'b1;
        tick();
        bus4.valid_i = 1'b0;
        #1;
        chk4("rst_mid0", 1, 8'h11, 0, 0);
        tick();
        chk4("rst_mid1", 1, 8'h22, 0, 0);
        tick();
        chk4("rst_mid2", 1, 8'h33, 0, 0);
        reset_n = 1'b0;
        #1;
        chk4("rst_async", 0, 8'h00, 0, 1);
        tick();
        reset_n = 1'b1;
        #1;
        chk4("rst_idle", 0, 8'h00, 0, 1);
        bus4.valid_i = 1'b1;
        bus4.data_i  = 32'h08070605;
        tick();
        bus4.valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk4($sformatf("post_rst%0d", i), 1, 8'(8'h05 + i), (i == 3), (i == 3));
            tick();
        end
        #1;
        chk4("post_rst_end", 0, 8'h00, 0, 1);

        // Non-power-of-two depth: two back-to-back 3x4 vectors.
        d3 = '{4'h1, 4'h2, 4'h3, 4'hA, 4'hB, 4'hC};
        l3 = '{0, 0, 1, 0, 0, 1};
        bus3.valid_i = 1'b1;
        bus3.data_i  = 12'h321;
        bus3.ready_i = 1'b1;
        #1;
        chk("d3_ready_load", 32'(bus3.ready_o), 32'd1);
        tick();
        bus3.data_i = 12'hCBA;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) bus3.valid_i = 1'b0;
            #1;
            chk3($sformatf("d3_%0d", i), 1, d3[i], l3[i]);
            if (i == 2) chk("d3_ready_last", 32'(bus3.ready_o), 32'd1);
            tick();
        end
        #1;
        chk3("d3_end", 0, 4'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
